// File: rtl/fp32_pkg.sv
// Shared binary32 definitions: field widths, special encodings, and the
// unpacked-operand view used by the floating-point datapaths.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int SIG_W   = MAN_W + 1;
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  // Magnitude-ordered operand as carried between pipeline stages.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_mag_t;

  // Subnormals classify as zero, so their significand is forced to zero.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.is_zero = (u.exp == '0);
    u.is_inf  = (u.exp == '1) && (x[22:0] == '0);
    u.is_nan  = (u.exp == '1) && (x[22:0] != '0);
    u.sig     = u.is_zero ? '0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// 26-bit leading-zero counter; an all-zero input reports 26.
module fp_lzc (
  input  logic [25:0] data,
  output logic [4:0]  count
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    count = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (data[i]) count = 5'(25 - i);
    end
  end

endmodule

// File: rtl/add_floating.sv
// Four-stage binary32 adder with RNE rounding, flush-to-zero on subnormals,
// and an input capture register ahead of the arithmetic stages.
module add_floating
  import fp32_pkg::*;
(
  input  logic        aclk,
  input  logic        areset,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);

  assign s_axis_a_tready = ~areset;
  assign s_axis_b_tready = ~areset;

  logic        s0_valid, s1_valid, s2_valid, s3_valid;
  logic [31:0] s0_a, s0_b;

  // Stage 1: unpack, classify, order by magnitude.
  fp_unpacked_t ua, ub;
  fp_mag_t      big_c, small_c;
  logic         special_c;
  logic [31:0]  special_val_c;

  always_comb begin
    ua            = fp_unpack(s0_a);
    ub            = fp_unpack(s0_b);
    special_c     = 1'b1;
    special_val_c = QNAN;
    if ({ua.exp, ua.sig} >= {ub.exp, ub.sig}) begin
      big_c   = {ua.sign, ua.exp, ua.sig};
      small_c = {ub.sign, ub.exp, ub.sig};
    end else begin
      big_c   = {ub.sign, ub.exp, ub.sig};
      small_c = {ua.sign, ua.exp, ua.sig};
    end
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)))
      special_val_c = QNAN;
    else if (ua.is_inf)
      special_val_c = POS_INF | {ua.sign, 31'b0};
    else if (ub.is_inf)
      special_val_c = POS_INF | {ub.sign, 31'b0};
    else if (ua.is_zero && ub.is_zero)
      special_val_c = {ua.sign & ub.sign, 31'b0};
    else
      special_c = 1'b0;
  end

  fp_mag_t     s1_big, s1_small;
  logic        s1_special;
  logic [31:0] s1_special_val;

  // Stage 2: align the smaller significand, keeping guard, round and sticky.
  logic [EXP_W-1:0] diff;
  logic [49:0]      shifted;
  logic [26:0]      small_ext_c;

  always_comb begin
    diff    = s1_big.exp - s1_small.exp;
    shifted = {s1_small.sig, 26'b0} >> diff;
    if (diff > 8'd26)
      small_ext_c = {26'b0, |s1_small.sig};
    else
      small_ext_c = {shifted[49:24], |shifted[23:0]};
  end

  logic             s2_sign, s2_eff_sub, s2_special;
  logic [EXP_W-1:0] s2_exp;
  logic [SIG_W-1:0] s2_big_sig;
  logic [26:0]      s2_small_ext;
  logic [31:0]      s2_special_val;

  // Stage 3: add or subtract; the larger magnitude leads, so no sign flip.
  logic [27:0] sum_c;
  logic [4:0]  lzc_c;

  always_comb begin
    if (s2_eff_sub)
      sum_c = {1'b0, s2_big_sig, 3'b000} - {1'b0, s2_small_ext};
    else
      sum_c = {1'b0, s2_big_sig, 3'b000} + {1'b0, s2_small_ext};
  end

  // Below bit 2 a nonzero sum only arises when alignment kept no low bits.
  fp_lzc u_lzc (
    .data  (sum_c[27:2]),
    .count (lzc_c)
  );

  logic             s3_sign, s3_special;
  logic [EXP_W-1:0] s3_exp;
  logic [27:0]      s3_sum;
  logic [4:0]       s3_lzc;
  logic [31:0]      s3_special_val;

  // Stage 4: normalise so the leading one sits at bit 27, round, pack.
  logic [27:0]       norm;
  logic              round_up;
  logic [23:0]       rounded;
  logic signed [9:0] exp_n;
  logic [31:0]       result_c;

  always_comb begin
    norm     = s3_sum << s3_lzc;
    round_up = norm[3] & ((|norm[2:0]) | norm[4]);
    rounded  = {1'b0, norm[26:4]} + 24'(round_up);
    exp_n    = $signed({2'b00, s3_exp}) + 10'sd1 - $signed({5'b00000, s3_lzc})
             + $signed({9'd0, rounded[23]});
    if (s3_special)
      result_c = s3_special_val;
    else if (!norm[27])
      result_c = '0;
    else if (exp_n >= 10'(EXP_MAX))
      result_c = POS_INF | {s3_sign, 31'b0};
    else if (exp_n <= 10'sd0)
      result_c = {s3_sign, 31'b0};
    else
      result_c = {s3_sign, exp_n[7:0], rounded[22:0]};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s0_valid             <= 1'b0;
      s1_valid             <= 1'b0;
      s2_valid             <= 1'b0;
      s3_valid             <= 1'b0;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
    end else begin
      s0_valid             <= s_axis_a_tvalid & s_axis_b_tvalid;
      s1_valid             <= s0_valid;
      s2_valid             <= s1_valid;
      s3_valid             <= s2_valid;
      m_axis_result_tvalid <= s3_valid;
      if (s3_valid) m_axis_result_tdata <= result_c;
    end
  end

  // NOTE: datapath registers carry no reset; the valid chain alone decides
  // whether their contents are ever observed.
  always_ff @(posedge aclk) begin
    s0_a           <= s_axis_a_tdata;
    s0_b           <= s_axis_b_tdata;
    s1_big         <= big_c;
    s1_small       <= small_c;
    s1_special     <= special_c;
    s1_special_val <= special_val_c;
    s2_sign        <= s1_big.sign;
    s2_eff_sub     <= s1_big.sign ^ s1_small.sign;
    s2_exp         <= s1_big.exp;
    s2_big_sig     <= s1_big.sig;
    s2_small_ext   <= small_ext_c;
    s2_special     <= s1_special;
    s2_special_val <= s1_special_val;
    s3_sign        <= s2_sign;
    s3_exp         <= s2_exp;
    s3_sum         <= sum_c;
    s3_lzc         <= lzc_c;
    s3_special     <= s2_special;
    s3_special_val <= s2_special_val;
  end

endmodule

// File: tb/tb_add_floating.sv
// Scoreboard bench for add_floating: directed cases plus randomized operands
// checked against an exact-integer binary32 reference model.
module tb_add_floating;
  import fp32_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        a_tvalid = 1'b0, b_tvalid = 1'b0;
  logic        a_tready, b_tready;
  logic [31:0] a_tdata = '0, b_tdata = '0;
  logic        r_tvalid;
  logic [31:0] r_tdata;

  add_floating dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_axis_a_tvalid      (a_tvalid),
    .s_axis_a_tready      (a_tready),
    .s_axis_a_tdata       (a_tdata),
    .s_axis_b_tvalid      (b_tvalid),
    .s_axis_b_tready      (b_tready),
    .s_axis_b_tdata       (b_tdata),
    .m_axis_result_tvalid (r_tvalid),
    .m_axis_result_tdata  (r_tdata)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          edge_n;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  logic [31:0] last_data = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Exact reference: align both operands as integers, sum, then round RNE.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, emin, shift, p, e_res;
    logic [63:0] ma, mb, m, q, rem, half;
    longint      va, vb, s;
    logic        sgn;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = 64'(a[22:0]);
    mb = 64'(b[22:0]);
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return QNAN;
    if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : QNAN;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return {a[31] & b[31], 31'b0};
    if (ea == 0) return b;
    if (eb == 0) return a;
    if (ea - eb >= 26) return a;
    if (eb - ea >= 26) return b;
    ma   = ma | (64'd1 << 23);
    mb   = mb | (64'd1 << 23);
    emin = (ea < eb) ? ea : eb;
    va   = longint'(ma << (ea - emin));
    vb   = longint'(mb << (eb - emin));
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    s = va + vb;
    if (s == 0) return 32'h0000_0000;
    sgn = (s < 0);
    m   = 64'(sgn ? -s : s);
    p   = 0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    shift = p - 23;
    if (shift > 0) begin
      q    = m >> shift;
      rem  = m - (q << shift);
      half = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q     = q >> 1;
        shift = shift + 1;
      end
    end else begin
      q = m << (-shift);
    end
    e_res = emin + shift;
    if (e_res >= 255) return {sgn, 8'hFF, 23'b0};
    if (e_res <= 0) return {sgn, 31'b0};
    return {sgn, e_res[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] ref_op);
    int e;
    e = int'(ref_op[30:23]);
    case ($urandom_range(0, 9))
      0, 1, 2: return $urandom;
      3, 4, 5: begin
        e = e + int'($urandom_range(0, 6)) - 3;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom), e[7:0], 23'($urandom)};
      end
      6: case ($urandom_range(0, 9))
        0: return 32'h0000_0000;
        1: return 32'h8000_0000;
        2: return 32'h7F80_0000;
        3: return 32'hFF80_0000;
        4: return 32'h7FC0_0001;
        5: return 32'h0040_0000;
        6: return 32'h7F7F_FFFF;
        7: return 32'hFF7F_FFFF;
        8: return 32'h0080_0000;
        default: return 32'h8080_0000;
      endcase
      7: return {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
      8: return {1'($urandom), 8'($urandom_range(1, 4)), 23'($urandom)};
      default: return {~ref_op[31], ref_op[30:0] ^ 31'($urandom_range(0, 3))};
    endcase
  endfunction

  task automatic drive(input logic va, input logic vb, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv);
    exp_t item;
    @(negedge aclk);
    a_tvalid = va;
    b_tvalid = vb;
    a_tdata  = a;
    b_tdata  = b;
    if (va && vb) begin
      item.a      = a;
      item.b      = b;
      item.res    = expv;
      item.edge_n = cyc + 1;
      sb.push_back(item);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: samples just after the falling edge, away from the active edge.
  always @(negedge aclk) begin
    exp_t e;
    #2;
    if (areset) begin
      check("reset_a_tready", 32'(a_tready), 32'd0);
      check("reset_b_tready", 32'(b_tready), 32'd0);
      check("reset_tvalid", 32'(r_tvalid), 32'd0);
      check("reset_tdata", r_tdata, 32'd0);
      last_data = '0;
    end else if (r_tvalid) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h with no pending operation (cycle %0d)", r_tdata, cyc);
      end else begin
        e = sb.pop_front();
        check($sformatf("sum %h+%h", e.a, e.b), r_tdata, e.res);
        check("latency", 32'(cyc), 32'(e.edge_n + 4));
      end
      last_data = r_tdata;
    end else begin
      check("hold_tdata", r_tdata, last_data);
    end
  end

  initial begin
    int          p0;
    logic [31:0] a, b;

    idle(3);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("tready_after_reset", 32'({a_tready, b_tready}), 32'd3);

    // Lone operands are dropped and never produce a result.
    p0 = pulses;
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 32'h420A3D71, 32'h41F5EB85, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h420A3D71, 32'h41F5EB85, 32'h0);
    idle(6);
    check("lone_operand_pulses", 32'(pulses), 32'(p0));

    // Continuous issue of the basic sum, then alternating large-gap pairs.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 32'h420A3D71, 32'h41F5EB85, 32'h4282999A);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1'b1, 1'b1, 32'h520A3D71, 32'h6BF5EB85, 32'h6BF5EB85);
      else            drive(1'b1, 1'b1, 32'h520A3D71, 32'h6AB7EB85, 32'h6AB7EB85);
    end

    // Special operands.
    drive(1'b1, 1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    drive(1'b1, 1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000);
    drive(1'b1, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    drive(1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h80000000);
    drive(1'b1, 1'b1, 32'h00400000, 32'h00000000, 32'h00000000);
    drive(1'b1, 1'b1, 32'h00000000, 32'h80000000, 32'h00000000);
    drive(1'b1, 1'b1, 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    drive(1'b1, 1'b1, 32'hFF800000, 32'h42000000, 32'hFF800000);
    idle(8);

    // Reset two cycles after an issue discards the in-flight operation.
    p0 = pulses;
    drive(1'b1, 1'b1, 32'h420A3D71, 32'h41F5EB85, 32'h4282999A);
    idle(2);
    @(negedge aclk);
    areset = 1'b1;
    sb.delete();
    @(negedge aclk);
    areset = 1'b0;
    idle(8);
    check("reset_midflight_pulses", 32'(pulses), 32'(p0));

    // Randomized operands with occasional bubbles and lone valids.
    for (int n = 0; n < 1500; n++) begin
      a = rand_op($urandom);
      b = rand_op(a);
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] t;
        t = a; a = b; b = t;
      end
      case ($urandom_range(0, 7))
        0:       drive(1'b0, 1'b0, a, b, 32'h0);
        1:       drive(1'b1, 1'b0, a, b, 32'h0);
        2:       drive(1'b0, 1'b1, a, b, 32'h0);
        default: drive(1'b1, 1'b1, a, b, ref_add(a, b));
      endcase
    end
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
